pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the rvcpu in-order core, replacing the fixed six-stage stall-only controller. It takes per-stage stall and flush requests and a halt request, and produces per-register stall, bubble and flush enables for the pipeline flops between the stages. It also sequences a clean halt, draining in-flight instructions before asserting `halted`. It sits at top level beside the pipeline registers; `stall[0]` gates the PC register and `stall[j]` gates the register written from stage j.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_if.sv | 37 +++
 rtl/pipe_ctrl_sat_counter.sv | 34 +++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the rvcpu pipeline hazard controller.
// Optional perf counters are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  localparam int NumStages = 6;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } pipe_state_t;

  typedef logic [NumStages-1:0] stage_vec_t;

  // Drain counter load value: instructions still in flight past fetch.
  function automatic int drain_len(input int stages);
    return stages - 2;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between pipeline stages and pipe_ctrl.
// Same in both builds; PIPE_CTRL_PERF_EN only adds a top-level port.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int Stages = NumStages
) ();

  logic [Stages-1:0] stallreq;
  logic [Stages-1:0] flushreq;
  logic              halt_req;
  logic [Stages-1:0] stall;
  logic [Stages-1:0] bubble;
  logic [Stages-1:0] flush;
  logic              halted;

  modport master (
    output stallreq,
    output flushreq,
    output halt_req,
    input  stall,
    input  bubble,
    input  flush,
    input  halted
  );

  modport slave (
    input  stallreq,
    input  flushreq,
    input  halt_req,
    output stall,
    output bubble,
    output flush,
    output halted
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for per-stage stall statistics.
// Only built when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module sat_counter #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;
  logic [Width-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) begin
      q_d = q_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush decode and halt drain.
// Define PIPE_CTRL_PERF_EN for per-stage saturating stall counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int Stages = NumStages
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CtrWidth = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  pipe_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [Stages-1:0][CtrWidth-1:0] stall_cycles
`endif
);

  localparam int CntW = $clog2(Stages);
  localparam logic [CntW-1:0] DrainLoad = CntW'(drain_len(Stages));

  pipe_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic halted_q, halted_d;

  int   k;
  int   f;
  logic has_stall;
  logic flush_eff;

  logic [Stages-1:0] stall_v;
  logic [Stages-1:0] bubble_v;
  logic [Stages-1:0] flush_v;

  // k = -1 when nothing stalls, so k < f also covers the no-stall case.
  always_comb begin
    k = -1;
    for (int i = 0; i < Stages; i++) begin
      if (bus.stallreq[i]) begin
        k = i;
      end
    end
    f = 0;
    for (int i = 1; i < Stages; i++) begin
      if (bus.flushreq[i]) begin
        f = i;
      end
    end
    has_stall = (k >= 0);
    flush_eff = (f >= 1) && (k < f);
  end

  always_comb begin
    stall_v  = '0;
    bubble_v = '0;
    flush_v  = '0;
    for (int j = 0; j < Stages; j++) begin
      stall_v[j]  = (j <= k);
      bubble_v[j] = has_stall && (j == k + 1);
      flush_v[j]  = flush_eff && (j >= 1) && (j < f);
    end
    stall_v = stall_v & ~flush_v;
    if (state_q == DRAIN) begin
      stall_v[0]  = 1'b1;
      bubble_v[1] = 1'b1;
    end
    if (state_q == HALTED) begin
      stall_v  = '1;
      bubble_v = '0;
      flush_v  = '0;
    end
    if (rst) begin
      stall_v  = '0;
      bubble_v = '0;
      flush_v  = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    unique case (state_q)
      RUN: begin
        if (bus.halt_req && !flush_eff) begin
          state_d = DRAIN;
          cnt_d   = DrainLoad;
        end
      end
      DRAIN: begin
        if (!has_stall) begin
          if (cnt_q <= CntW'(1)) begin
            state_d  = HALTED;
            halted_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign bus.stall  = stall_v;
  assign bus.bubble = bubble_v;
  assign bus.flush  = flush_v;
  assign bus.halted = halted_q & ~rst;

`ifdef PIPE_CTRL_PERF_EN
  for (genvar j = 0; j < Stages; j++) begin : g_ctr
    sat_counter #(
      .Width(CtrWidth)
    ) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (stall_v[j] && (state_q != HALTED)),
      .q   (stall_cycles[j])
    );
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a mask-arithmetic model.
// Perf counter scenario is built when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int S = NumStages;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.Stages(S)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  localparam int CW = 4;
  logic [S-1:0][CW-1:0] stall_cycles;
  pipe_ctrl #(.Stages(S), .CtrWidth(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cycles(stall_cycles)
  );
`else
  pipe_ctrl #(.Stages(S)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  function automatic int msb(input stage_vec_t v);
    int r;
    r = -1;
    for (int i = 0; i < S; i++) if (v[i]) r = i;
    return r;
  endfunction

  // RUN-mode outputs expressed as bit masks.
  function automatic void model(
    input  stage_vec_t s,
    input  stage_vec_t fr,
    output stage_vec_t es,
    output stage_vec_t eb,
    output stage_vec_t ef,
    output bit         fok
  );
    int k;
    int f;
    k   = msb(s);
    f   = msb(fr & ~stage_vec_t'(1));
    es  = stage_vec_t'((1 << (k + 1)) - 1);
    eb  = (k >= 0 && k < S - 1) ? stage_vec_t'(1 << (k + 1)) : '0;
    fok = (f >= 1) && (k < f);
    ef  = fok ? stage_vec_t'((1 << f) - 2) : '0;
    es  = es & ~ef;
  endfunction

  task automatic drive(input stage_vec_t s, input stage_vec_t f, input logic h);
    @(negedge clk);
    bus.stallreq = s;
    bus.flushreq = f;
    bus.halt_req = h;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stallreq = '0;
    bus.flushreq = '0;
    bus.halt_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stallreq = 6'b010100;
    bus.flushreq = 6'b100000;
    bus.halt_req = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.stall, bus.bubble, bus.flush, bus.halted} !== 19'b0) begin
      failures++;
      $display("FAIL reset: got %b %b %b %b required all zero",
               bus.stall, bus.bubble, bus.flush, bus.halted);
    end
    do_reset();
  endtask

  task automatic test_directed();
    stage_vec_t sv [5] = '{6'b000100, 6'b000000, 6'b010000, 6'b001000, 6'b000000};
    stage_vec_t fv [5] = '{6'b000000, 6'b001000, 6'b001000, 6'b001000, 6'b000001};
    logic [18:0] ev [5] = '{
      {6'b000111, 6'b001000, 6'b000000, 1'b0},
      {6'b000000, 6'b000000, 6'b000110, 1'b0},
      {6'b011111, 6'b100000, 6'b000000, 1'b0},
      {6'b001111, 6'b010000, 6'b000000, 1'b0},
      {6'b000000, 6'b000000, 6'b000000, 1'b0}
    };
    for (int i = 0; i < 5; i++) begin
      drive(sv[i], fv[i], 1'b0);
      checks++;
      if ({bus.stall, bus.bubble, bus.flush, bus.halted} !== ev[i]) begin
        failures++;
        $display("FAIL directed[%0d]: got %b required %b", i,
                 {bus.stall, bus.bubble, bus.flush, bus.halted}, ev[i]);
      end
    end
  endtask

  task automatic test_random_run();
    stage_vec_t s, f, es, eb, ef;
    bit fok;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 2) == 0) ? '0 : stage_vec_t'($urandom);
      f = ($urandom_range(0, 2) == 0) ? '0 : stage_vec_t'($urandom);
      model(s, f, es, eb, ef, fok);
      drive(s, f, 1'b0);
      checks++;
      if ({bus.stall, bus.bubble, bus.flush, bus.halted} !== {es, eb, ef, 1'b0}) begin
        failures++;
        $display("FAIL random_run s=%b f=%b: got %b required %b", s, f,
                 {bus.stall, bus.bubble, bus.flush, bus.halted}, {es, eb, ef, 1'b0});
      end
    end
  endtask

  // Halt pulse, then optional stallreq[3] burst and a flush mid-drain.
  task automatic test_drain(input int st_at, input int st_len, input int fl_at,
                            input string name);
    stage_vec_t s, f, es, eb, ef;
    bit fok;
    int halt_c;
    logic [18:0] exp_v;
    do_reset();
    drive('0, '0, 1'b1);
    checks++;
    if ({bus.stall, bus.bubble, bus.flush, bus.halted} !== 19'b0) begin
      failures++;
      $display("FAIL %s halt_cycle: got %b required 0", name,
               {bus.stall, bus.bubble, bus.flush, bus.halted});
    end
    halt_c = S - 1 + st_len;
    for (int c = 1; c <= halt_c + 1; c++) begin
      s = (c >= st_at && c < st_at + st_len) ? 6'b001000 : 6'b000000;
      f = (c == fl_at) ? 6'b010000 : 6'b000000;
      model(s, f, es, eb, ef, fok);
      if (c >= halt_c) exp_v = {6'b111111, 6'b000000, 6'b000000, 1'b1};
      else exp_v = {es | 6'b000001, eb | 6'b000010, ef, 1'b0};
      drive(s, f, 1'b0);
      checks++;
      if ({bus.stall, bus.bubble, bus.flush, bus.halted} !== exp_v) begin
        failures++;
        $display("FAIL %s c=%0d: got %b required %b", name, c,
                 {bus.stall, bus.bubble, bus.flush, bus.halted}, exp_v);
      end
    end
  endtask

  task automatic test_halted_ignores();
    stage_vec_t s, f;
    for (int i = 0; i < 10; i++) begin
      s = stage_vec_t'($urandom);
      f = stage_vec_t'($urandom);
      drive(s, f, 1'($urandom));
      checks++;
      if ({bus.stall, bus.bubble, bus.flush, bus.halted} !==
          {6'b111111, 6'b000000, 6'b000000, 1'b1}) begin
        failures++;
        $display("FAIL halted_ignores: got %b required %b",
                 {bus.stall, bus.bubble, bus.flush, bus.halted},
                 {6'b111111, 6'b000000, 6'b000000, 1'b1});
      end
    end
  endtask

  task automatic test_reset_in_halted();
    @(negedge clk);
    rst = 1'b1;
    bus.stallreq = '0;
    bus.flushreq = '0;
    bus.halt_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.stall, bus.bubble, bus.flush, bus.halted} !== 19'b0) begin
      failures++;
      $display("FAIL reset_in_halted: got %b required 0",
               {bus.stall, bus.bubble, bus.flush, bus.halted});
    end
    rst = 1'b0;
    drive(6'b000010, '0, 1'b0);
    checks++;
    if ({bus.stall, bus.bubble, bus.flush, bus.halted} !==
        {6'b000011, 6'b000100, 6'b000000, 1'b0}) begin
      failures++;
      $display("FAIL after_reset_run: got %b required %b",
               {bus.stall, bus.bubble, bus.flush, bus.halted},
               {6'b000011, 6'b000100, 6'b000000, 1'b0});
    end
  endtask

  task automatic test_halt_flush();
    stage_vec_t hs [3] = '{6'b000000, 6'b000000, 6'b010000};
    stage_vec_t hf [3] = '{6'b001000, 6'b000001, 6'b001000};
    bit         hd [3] = '{1'b0, 1'b1, 1'b1};
    logic exp_b;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      drive(hs[i], hf[i], 1'b1);
      drive('0, '0, 1'b0);
      exp_b = hd[i];
      checks++;
      if (bus.stall[0] !== exp_b || bus.bubble[1] !== exp_b) begin
        failures++;
        $display("FAIL halt_flush[%0d]: got stall0=%b bubble1=%b required %b",
                 i, bus.stall[0], bus.bubble[1], exp_b);
      end
    end
  endtask

  task automatic test_random_drain();
    int a, l, fl;
    for (int t = 0; t < 6; t++) begin
      a  = $urandom_range(1, 3);
      l  = $urandom_range(0, 4);
      fl = $urandom_range(1, 4);
      test_drain(a, l, fl, "random_drain");
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    logic [CW-1:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) drive(6'b000100, '0, 1'b0);
    drive('0, '0, 1'b0);
    for (int j = 0; j < S; j++) begin
      e = (j <= 2) ? CW'(15) : CW'(0);
      checks++;
      if (stall_cycles[j] !== e) begin
        failures++;
        $display("FAIL perf_sat[%0d]: got %0d required %0d", j, stall_cycles[j], e);
      end
    end
    do_reset();
    for (int i = 0; i < 3; i++) drive(6'b000010, '0, 1'b0);
    drive('0, '0, 1'b0);
    for (int j = 0; j < S; j++) begin
      e = (j <= 1) ? CW'(3) : CW'(0);
      checks++;
      if (stall_cycles[j] !== e) begin
        failures++;
        $display("FAIL perf_count[%0d]: got %0d required %0d", j, stall_cycles[j], e);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.stallreq = '0;
    bus.flushreq = '0;
    bus.halt_req = 1'b0;
    test_reset();
    test_directed();
    test_random_run();
    test_drain(0, 0, 0, "drain_plain");
    test_halted_ignores();
    test_reset_in_halted();
    test_drain(2, 2, 0, "drain_stall2");
    test_drain(0, 0, 2, "drain_flush");
    test_halt_flush();
    test_random_drain();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
